rtop_sm: RTL and testbench

RTOP_SM -- requirements
Module: rtop_sm

---
 rtl/rtop_pkg.sv | 48 ++++
 rtl/rtop_cordic_step.sv | 39 +++
 rtl/rtop_sm.sv | 170 +++++++++++++++++
 tb/tb_rtop_sm.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rtop_pkg.sv
// Shared definitions for the rectangular-to-polar converter: FSM states,
// the atan(2^-i) table in degrees, the CORDIC gain and the latency overhead.
package rtop_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_SCALE,
    S_DONE
  } state_t;

  // Angle accumulator: degrees with ATAN_FRAC fractional bits, signed.
  localparam int ATAN_FRAC = 8;
  localparam int ZW        = 20;

  // CORDIC gain 1/prod(sqrt(1+2^-2i)) ~ 0.607253 in Q0.16.
  localparam int          K_FRAC = 16;
  localparam logic [15:0] K_GAIN = 16'd39797;

  // Cycles beyond the micro-rotations: LOAD, SCALE and DONE.
  localparam int LAT_OVERHEAD = 3;

  // atan(2^-i) in degrees, scaled by 2^ATAN_FRAC and rounded.
  function automatic logic signed [ZW-1:0] atan_deg(input logic [3:0] i);
    logic signed [ZW-1:0] a;
    case (i)
      4'd0:    a = 20'sd11520;
      4'd1:    a = 20'sd6801;
      4'd2:    a = 20'sd3593;
      4'd3:    a = 20'sd1824;
      4'd4:    a = 20'sd916;
      4'd5:    a = 20'sd458;
      4'd6:    a = 20'sd229;
      4'd7:    a = 20'sd115;
      4'd8:    a = 20'sd57;
      4'd9:    a = 20'sd29;
      4'd10:   a = 20'sd14;
      4'd11:   a = 20'sd7;
      4'd12:   a = 20'sd4;
      4'd13:   a = 20'sd2;
      4'd14:   a = 20'sd1;
      default: a = 20'sd0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/rtop_cordic_step.sv
// One CORDIC vectoring micro-rotation: rotates (x,y) toward the +x axis by
// atan(2^-shift) and accumulates the rotation into the angle z.
module rtop_cordic_step
  import rtop_pkg::*;
#(
  parameter int XW = 19
) (
  input  logic signed [XW-1:0] x,
  input  logic signed [XW-1:0] y,
  input  logic signed [ZW-1:0] z,
  input  logic [3:0]           shift,
  output logic signed [XW-1:0] x_nxt,
  output logic signed [XW-1:0] y_nxt,
  output logic signed [ZW-1:0] z_nxt
);

  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;

  assign x_sh = x >>> shift;
  assign y_sh = y >>> shift;

  // Rotate against the sign of y so y is driven toward zero.
  always_comb begin
    x_nxt = x;
    y_nxt = y;
    z_nxt = z;
    if (y[XW-1]) begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - atan_deg(shift);
    end else begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + atan_deg(shift);
    end
  end

endmodule

// File: rtl/rtop_sm.sv
// Rectangular-to-polar converter: sequential CORDIC vectoring engine.
// Optional quadrant output `outbit` is enabled with macro RTOP_SM_OUTBIT_EN.
module rtop_sm
  import rtop_pkg::*;
#(
  parameter int W    = 8,
  parameter int ITER = 12
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [W-1:0] X_in,
  input  logic [W-1:0] Y_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] Mag_out,
  output logic [8:0]   Angle_out
`ifdef RTOP_SM_OUTBIT_EN
  ,
  output logic [1:0]   outbit
`endif
);

  // Three integer guard bits keep |(-128,-128)| * 1.647 in range; the
  // fractional bits preserve precision through the right shifts.
  localparam int FRAC = 8;
  localparam int XW   = W + 3 + FRAC;
  localparam int PW   = XW + K_FRAC;

  localparam logic [3:0]           CNT_LAST = 4'(ITER - 1);
  localparam logic [W-1:0]         MAG_MAX  = '1;
  localparam logic signed [ZW-1:0] ZHALF    = ZW'(1 << (ATAN_FRAC - 1));

  state_t state, nxt;

  logic signed [XW-1:0] x_r, y_r, x_nxt, y_nxt;
  logic signed [ZW-1:0] z_r, z_nxt;
  logic [3:0]           cnt;
  logic                 off180;
  logic [W-1:0]         mag_r;
  logic [8:0]           ang_r;

  // Scale by K with round-to-nearest, saturating to W bits.
  function automatic logic [W-1:0] mag_round(input logic signed [XW-1:0] xv);
    logic [PW-1:0] p;
    p = PW'($unsigned(xv)) * PW'(K_GAIN);
    p = p + (PW'(1) << (K_FRAC + FRAC - 1));
    p = p >> (K_FRAC + FRAC);
    if (p > PW'(MAG_MAX)) return MAG_MAX;
    return p[W-1:0];
  endfunction

  // Round the accumulated angle to whole degrees, add the fold offset and
  // wrap into 0..359.
  function automatic logic [8:0] angle_wrap(input logic signed [ZW-1:0] zv,
                                            input logic off);
    logic signed [ZW-1:0] d;
    d = (zv + ZHALF) >>> ATAN_FRAC;
    if (off) d = d + ZW'(180);
    if (d < ZW'(0)) d = d + ZW'(360);
    else if (d >= ZW'(360)) d = d - ZW'(360);
    return d[8:0];
  endfunction

`ifdef RTOP_SM_OUTBIT_EN
  function automatic logic [1:0] quadrant(input logic [8:0] a);
    if (a >= 9'd270) return 2'd3;
    if (a >= 9'd180) return 2'd2;
    if (a >= 9'd90)  return 2'd1;
    return 2'd0;
  endfunction
`endif

  rtop_cordic_step #(.XW(XW)) u_step (
    .x     (x_r),
    .y     (y_r),
    .z     (z_r),
    .shift (cnt),
    .x_nxt (x_nxt),
    .y_nxt (y_nxt),
    .z_nxt (z_nxt)
  );

  assign busy = (state != S_IDLE);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= nxt;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start) nxt = S_LOAD;
      S_LOAD:  nxt = S_ITER;
      S_ITER:  if (cnt == CNT_LAST) nxt = S_SCALE;
      S_SCALE: nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Datapath and result registers, sequenced by the current state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      cnt       <= '0;
      off180    <= 1'b0;
      mag_r     <= '0;
      ang_r     <= '0;
      done      <= 1'b0;
      Mag_out   <= '0;
      Angle_out <= '0;
`ifdef RTOP_SM_OUTBIT_EN
      outbit    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            x_r <= {{(XW-W-FRAC){X_in[W-1]}}, X_in, {FRAC{1'b0}}};
            y_r <= {{(XW-W-FRAC){Y_in[W-1]}}, Y_in, {FRAC{1'b0}}};
          end
        end
        S_LOAD: begin
          if (x_r[XW-1]) begin
            x_r    <= -x_r;
            y_r    <= -y_r;
            off180 <= 1'b1;
          end else begin
            off180 <= 1'b0;
          end
          z_r <= '0;
          cnt <= '0;
        end
        S_ITER: begin
          x_r <= x_nxt;
          y_r <= y_nxt;
          z_r <= z_nxt;
          cnt <= cnt + 4'd1;
        end
        S_SCALE: begin
          // A zero vector leaves x at zero; its angle is defined as 0.
          if (x_r == '0) begin
            mag_r <= '0;
            ang_r <= '0;
          end else begin
            mag_r <= mag_round(x_r);
            ang_r <= angle_wrap(z_r, off180);
          end
        end
        S_DONE: begin
          Mag_out   <= mag_r;
          Angle_out <= ang_r;
          done      <= 1'b1;
`ifdef RTOP_SM_OUTBIT_EN
          outbit    <= quadrant(ang_r);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rtop_sm.sv
// Directed-vector bench for rtop_sm: table of polar conversions plus
// hand-written sequences for start-held, mid-conversion reset and priority.
module tb_rtop_sm;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic [7:0] X_in;
  logic [7:0] Y_in;
  logic       busy;
  logic       done;
  logic [7:0] Mag_out;
  logic [8:0] Angle_out;
`ifdef RTOP_SM_OUTBIT_EN
  logic [1:0] outbit;
`endif

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic signed [7:0] x;
    logic signed [7:0] y;
    int mlo;
    int mhi;
    int ang;
    int q;
  } vec_t;

  vec_t tv[10];

  rtop_sm #(.W(8), .ITER(12)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .X_in      (X_in),
    .Y_in      (Y_in),
    .busy      (busy),
    .done      (done),
    .Mag_out   (Mag_out),
    .Angle_out (Angle_out)
`ifdef RTOP_SM_OUTBIT_EN
    ,
    .outbit    (outbit)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Issue one start and wait (bounded) for done; lat counts edges after the
  // start-sampling edge until done is seen.
  task automatic do_conv(input logic signed [7:0] x, input logic signed [7:0] y,
                         output int lat, output int mag, output int ang);
    @(negedge CLK);
    X_in  = x;
    Y_in  = y;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    mag = int'(Mag_out);
    ang = int'(Angle_out);
  endtask

  initial begin
    int lat, mag, ang, ndone, first, last;

    tv[0] = '{8'sd4,    8'sd0,    4,   4,   0,   0};
    tv[1] = '{8'sd3,    8'sd4,    5,   5,   53,  0};
    tv[2] = '{-8'sd4,   -8'sd4,   6,   6,   225, 2};
    tv[3] = '{8'sd127,  -8'sd128, 180, 181, 315, 3};
    tv[4] = '{8'sd0,    -8'sd5,   5,   5,   270, 3};
    tv[5] = '{8'sd0,    8'sd0,    0,   0,   0,   0};
    tv[6] = '{-8'sd1,   8'sd0,    1,   1,   180, 2};
    tv[7] = '{8'sd0,    8'sd7,    7,   7,   90,  1};
    tv[8] = '{-8'sd128, -8'sd128, 181, 181, 225, 2};
    tv[9] = '{-8'sd128, 8'sd0,    128, 128, 180, 2};

    RST = 1'b1;
    start = 1'b0;
    X_in = '0;
    Y_in = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", int'(busy), 0, 0);
    check("rst_done", int'(done), 0, 0);
    check("rst_mag", int'(Mag_out), 0, 0);
    check("rst_angle", int'(Angle_out), 0, 0);
`ifdef RTOP_SM_OUTBIT_EN
    check("rst_outbit", int'(outbit), 0, 0);
`endif
    @(negedge CLK);
    RST = 1'b0;

    // Table: each conversion checks latency, result, one-cycle done and hold.
    for (int i = 0; i < 10; i++) begin
      do_conv(tv[i].x, tv[i].y, lat, mag, ang);
      check($sformatf("lat[%0d]", i), lat, 15, 15);
      check($sformatf("mag[%0d]", i), mag, tv[i].mlo, tv[i].mhi);
      check($sformatf("angle[%0d]", i), ang, tv[i].ang, tv[i].ang);
`ifdef RTOP_SM_OUTBIT_EN
      check($sformatf("outbit[%0d]", i), int'(outbit), tv[i].q, tv[i].q);
`endif
      @(posedge CLK);
      #1;
      check($sformatf("done_pulse[%0d]", i), int'(done), 0, 0);
      check($sformatf("mag_hold[%0d]", i), int'(Mag_out), tv[i].mlo, tv[i].mhi);
      check($sformatf("angle_hold[%0d]", i), int'(Angle_out), tv[i].ang, tv[i].ang);
    end

    // Start held high: one result every 16 cycles, first at cycle 15.
    @(negedge CLK);
    X_in = 8'd3;
    Y_in = 8'd4;
    start = 1'b1;
    ndone = 0;
    first = -1;
    last = 0;
    for (int c = 0; c < 64; c++) begin
      @(posedge CLK);
      #1;
      if (done) begin
        if (ndone == 0) first = c;
        else check("hold_gap", c - last, 16, 16);
        last = c;
        ndone++;
        check("hold_mag", int'(Mag_out), 5, 5);
        check("hold_angle", int'(Angle_out), 53, 53);
      end
    end
    start = 1'b0;
    check("hold_first", first, 15, 15);
    check("hold_count", ndone, 4, 4);
    repeat (2) @(posedge CLK);
    #1;
    check("hold_idle", int'(busy), 0, 0);

    // Reset during the 5th ITER cycle aborts without a done pulse.
    @(negedge CLK);
    X_in = 8'd3;
    Y_in = 8'd4;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    check("abort_busy_before", int'(busy), 1, 1);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    check("abort_busy", int'(busy), 0, 0);
    check("abort_done", int'(done), 0, 0);
    check("abort_mag", int'(Mag_out), 0, 0);
    check("abort_angle", int'(Angle_out), 0, 0);
    ndone = 0;
    repeat (20) begin
      @(posedge CLK);
      #1;
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0, 0);
    check("abort_mag_later", int'(Mag_out), 0, 0);

    do_conv(8'sd0, -8'sd5, lat, mag, ang);
    check("post_abort_lat", lat, 15, 15);
    check("post_abort_mag", mag, 5, 5);
    check("post_abort_angle", ang, 270, 270);

    // Reset wins over start on the same edge.
    @(negedge CLK);
    X_in = 8'd4;
    Y_in = 8'd0;
    start = 1'b1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("rst_prio_busy", int'(busy), 0, 0);
    check("rst_prio_mag", int'(Mag_out), 0, 0);
    RST = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_prio_idle", int'(busy), 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
